mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch path and the data-memory (MEM) stage.
- Fetch uses the PC output of the PC register; MEM stage issues loads and stores.
- Data accesses have priority. A fetch in flight is squashed on a branch flush.
- Produces per-requester stall requests for the pipeline control module, which drives the stall vector.

Parameters:
- DATA_W, 32, width of address and data buses.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous reset, active-low (0 = reset)
- if_req  input  1  fetch request; held until if_done
- if_addr  input  DATA_W  fetch address (PC)
- if_rdata  output  DATA_W  fetched instruction; valid while if_done=1
- if_done  output  1  one-cycle fetch completion pulse
- flush  input  1  branch taken; squash the current fetch
- mem_req  input  1  data request; held until mem_done
- mem_we  input  1  1 = store, 0 = load
- mem_addr  input  DATA_W  data address
- mem_wdata  input  DATA_W  store data
- mem_sel  input  4  byte enables
- mem_rdata  output  DATA_W  load data; valid while mem_done=1
- mem_done  output  1  one-cycle data completion pulse
- bus_req  output  1  bus cycle active
- bus_we  output  1  bus write enable
- bus_addr  output  DATA_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_sel  output  4  bus byte enables; fetches drive 4'hF
- bus_rdata  input  DATA_W  bus read data; valid with bus_ack
- bus_ack  input  1  bus completion, single-cycle
- bus_err  output  1  timeout pulse; tied 0 without the optional feature
- stall_if_req  output  1  if_req & ~if_done (combinational)
- stall_mem_req  output  1  mem_req & ~mem_done (combinational)

Behaviour:
- States: IDLE, IF_WAIT, MEM_WAIT, IF_DROP.
- Reset values (RST=0, immediate and asynchronous):
  - state = IDLE.
  - All registered outputs = 0: bus_req, bus_we, bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata, if_done, mem_done, bus_err.
  - Reset mid-transaction abandons the bus cycle; any later bus_ack is ignored.
- IDLE transitions:
  - mem_req=1 goes to MEM_WAIT. This wins over if_req.
  - Otherwise, if_req=1 and flush=0 goes to IF_WAIT.
  - if_req=1 together with flush=1 is not granted that cycle.
- Grant action: bus_* outputs are registered at the grant edge. bus_req=1 from the next cycle.
- Bus hold rule: addr, we, wdata and sel stay stable while bus_req=1. They change only on a new grant.
- Ack handling: bus_ack is sampled only while bus_req=1. On the edge where bus_ack=1:
  - bus_req goes to 0.
  - bus_rdata is latched into the owner's rdata.
  - The owner's done pulses for exactly one cycle.
  - state returns to IDLE.
- Latency: request seen in IDLE at cycle 0; bus_req=1 in cycle 1; ack in cycle k gives done in cycle k+1. Minimum is 2 cycles.
- Bubble: one IDLE cycle always separates back-to-back transactions.
- Done pulses: if_done and mem_done are never high in the same cycle. Neither repeats without a new grant.
- Flush:
  - flush=1 in IF_WAIT goes to IF_DROP. bus_req stays high until ack, because the bus cycle cannot be cancelled.
  - On ack in IF_DROP: no if_done pulse, if_rdata unchanged, go to IDLE.
  - flush in MEM_WAIT or IDLE has no effect on state.
- Simultaneous flush and bus_ack in IF_WAIT: the ack is dropped, with no if_done.
- Stores: mem_rdata is unchanged and mem_done still pulses.
- Request drop: a requester that drops its req before done does not abort the bus cycle. Completion still pulses done.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit cycle counter clears on grant and increments each cycle bus_req=1.
  - When the counter reaches TIMEOUT_CYCLES without ack: bus_req goes to 0, bus_err pulses for one cycle, and the owner's done pulses with rdata = 0. A dropped fetch gets no done. State goes to IDLE.
  - A late bus_ack after timeout is ignored.
- When not defined: wait indefinitely for ack; bus_err is constant 0; no counter logic.

Test Plan:
- Reset and fetch: hold RST=0 3 cycles, release; if_req=1, if_addr=0x00000010; ack in cycle 3 with bus_rdata=0x00A00093 -> bus_req=1 in cycles 1..3, bus_sel=4'hF, if_done=1 in cycle 4 with if_rdata=0x00A00093; stall_if_req=1 in cycles 0..3.
- Priority: if_req and mem_req (load, addr 0x100) both high in IDLE -> data granted first; mem_done pulse; IDLE bubble; then fetch granted; if_done after its ack.
- Store: mem_we=1, addr 0x200, wdata 0xDEADBEEF, sel 4'b0011, ack after 2 cycles -> bus outputs match and stay stable until ack; mem_done pulses; mem_rdata unchanged.
- Flush: flush=1 in the cycle after fetch grant, ack 2 cycles later -> no if_done; next fetch to 0x40 completes normally. flush together with ack -> no if_done.
- Reset mid-cycle: RST=0 while bus_req=1 in MEM_WAIT -> bus_req=0 immediately; after release, ack=1 gives no done.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): load, no ack -> bus_err and mem_done pulse together after 4 bus_req cycles, mem_rdata=0; state IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, completion and external bus signals of mem_arbiter.
//
// Signal groups:
//   fetch port : if_req, if_addr, flush -> if_rdata, if_done, stall_if_req
//   data port  : mem_req, mem_we, mem_addr, mem_wdata, mem_sel
//                -> mem_rdata, mem_done, stall_mem_req
//   memory bus : bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err <- bus_rdata, bus_ack
//
// Modports:
//   master : the arbiter's view (drives bus and completion signals)
//   slave  : the surrounding pipeline and memory (drive requests and bus responses)

interface mem_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              flush;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_sel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_sel;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    logic              stall_if_req;
    logic              stall_mem_req;

    modport master (
        input  if_req, if_addr, flush,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  bus_rdata, bus_ack,
        output if_rdata, if_done, mem_rdata, mem_done,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        output stall_if_req, stall_mem_req
    );

    modport slave (
        output if_req, if_addr, flush,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output bus_rdata, bus_ack,
        input  if_rdata, if_done, mem_rdata, mem_done,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        input  stall_if_req, stall_mem_req
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between instruction fetch and the MEM stage.
// Data accesses win over fetches; a fetch in flight is squashed by a branch flush (the bus
// cycle still runs to its ack, but the result is discarded). One IDLE cycle always separates
// back-to-back bus cycles.
//
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous reset, active low
//   arb  : mem_arbiter_if.master (fetch port, data port, memory bus, stall requests)
//
// Optional feature, macro MEM_ARB_TIMEOUT_EN: bus watchdog. A bus cycle that sees no ack for
// TIMEOUT_CYCLES cycles is abandoned, bus_err pulses and the owner completes with rdata = 0.
// Without the macro the arbiter waits indefinitely and bus_err is tied low.

module mem_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master arb
);

    // Watchdog counter is 16 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StIfWait, StMemWait, StIfDrop} state_e;

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    // A request is still outstanding unless its done pulse is showing this cycle; the requester
    // only drops req after seeing done, so the done cycle must not re-grant it.
    logic if_pending, mem_pending;
    assign if_pending  = arb.if_req & ~if_done_q;
    assign mem_pending = arb.mem_req & ~mem_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_expire;
    logic        bus_err_q, bus_err_d;

    // Expires in the TIMEOUT_CYCLES-th cycle of bus_req.
    assign wd_expire = (32'(wd_cnt_q) + 32'd1) >= TIMEOUT_CYCLES;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == StIdle) begin
            wd_cnt_d = '0;
        end else if (bus_req_q) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign arb.bus_err = bus_err_q;
`else
    assign arb.bus_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (mem_pending) begin
                    state_d     = StMemWait;
                    bus_req_d   = 1'b1;
                    bus_we_d    = arb.mem_we;
                    bus_addr_d  = arb.mem_addr;
                    bus_wdata_d = arb.mem_wdata;
                    bus_sel_d   = arb.mem_sel;
                end else if (if_pending && !arb.flush) begin
                    state_d     = StIfWait;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = arb.if_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = 4'hF;
                end
            end
            StIfWait, StMemWait, StIfDrop: begin
                if (arb.bus_ack) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                    if (state_q == StMemWait) begin
                        mem_done_d = 1'b1;
                        if (!bus_we_q) begin
                            mem_rdata_d = arb.bus_rdata;
                        end
                    end else if (state_q == StIfWait && !arb.flush) begin
                        // A flush arriving with the ack discards the fetched word.
                        if_done_d  = 1'b1;
                        if_rdata_d = arb.bus_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == StMemWait) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = '0;
                    end else if (state_q == StIfWait && !arb.flush) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end
`endif
                else if (state_q == StIfWait && arb.flush) begin
                    // Bus cycle cannot be cancelled; keep it running and drop the result.
                    state_d = StIfDrop;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= 4'h0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign arb.bus_req       = bus_req_q;
    assign arb.bus_we        = bus_we_q;
    assign arb.bus_addr      = bus_addr_q;
    assign arb.bus_wdata     = bus_wdata_q;
    assign arb.bus_sel       = bus_sel_q;
    assign arb.if_rdata      = if_rdata_q;
    assign arb.mem_rdata     = mem_rdata_q;
    assign arb.if_done       = if_done_q;
    assign arb.mem_done      = mem_done_q;
    assign arb.stall_if_req  = if_pending;
    assign arb.stall_mem_req = mem_pending;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter, every cycle
// compared against a transaction-level reference model of the arbitration rules.

module tb_mem_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;
    localparam int OWN_IF  = 1;
    localparam int OWN_MEM = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    mem_arbiter_if #(.DATA_W(DW)) arb ();

    mem_arbiter #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .arb(arb)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction record plus the visible completion results.
    typedef struct {
        bit          busy;
        int          owner;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        logic [3:0]  sel;
        bit          squash;
        int          waited;
        bit          if_done;
        bit          mem_done;
        bit          err;
        logic [31:0] if_rdata;
        logic [31:0] mem_rdata;
    } model_t;

    model_t m;
    model_t mn;
    bit prev_if_done  = 1'b0;
    bit prev_mem_done = 1'b0;

    function automatic model_t model_reset();
        model_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic model_t model_next(input model_t c);
        model_t n;
        n = c;
        n.if_done  = 1'b0;
        n.mem_done = 1'b0;
        n.err      = 1'b0;
        if (!RST) return model_reset();
        if (c.busy) begin
            n.waited = c.waited + 1;
            if (arb.bus_ack) begin
                n.busy = 1'b0;
                if (c.owner == OWN_MEM) begin
                    n.mem_done = 1'b1;
                    if (!c.we) n.mem_rdata = arb.bus_rdata;
                end else if (!c.squash && !arb.flush) begin
                    n.if_done  = 1'b1;
                    n.if_rdata = arb.bus_rdata;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (c.waited + 1 >= int'(TMO)) begin
                n.busy = 1'b0;
                n.err  = 1'b1;
                if (c.owner == OWN_MEM) begin
                    n.mem_done  = 1'b1;
                    n.mem_rdata = 32'h0;
                end else if (!c.squash && !arb.flush) begin
                    n.if_done  = 1'b1;
                    n.if_rdata = 32'h0;
                end
            end
`endif
            else if (c.owner == OWN_IF && arb.flush) begin
                n.squash = 1'b1;
            end
        end else if (arb.mem_req && !c.mem_done) begin
            n.busy   = 1'b1;
            n.owner  = OWN_MEM;
            n.addr   = arb.mem_addr;
            n.we     = arb.mem_we;
            n.wdata  = arb.mem_wdata;
            n.sel    = arb.mem_sel;
            n.squash = 1'b0;
            n.waited = 0;
        end else if (arb.if_req && !c.if_done && !arb.flush) begin
            n.busy   = 1'b1;
            n.owner  = OWN_IF;
            n.addr   = arb.if_addr;
            n.we     = 1'b0;
            n.sel    = 4'hF;
            n.squash = 1'b0;
            n.waited = 0;
        end
        return n;
    endfunction

    task automatic check_outputs();
        check_eq("bus_req", 32'(arb.bus_req), 32'(m.busy));
        check_eq("bus_addr", arb.bus_addr, m.addr);
        check_eq("bus_we", 32'(arb.bus_we), 32'(m.we));
        check_eq("bus_sel", 32'(arb.bus_sel), 32'(m.sel));
        if (m.busy && m.owner == OWN_MEM) check_eq("bus_wdata", arb.bus_wdata, m.wdata);
        check_eq("if_done", 32'(arb.if_done), 32'(m.if_done));
        check_eq("mem_done", 32'(arb.mem_done), 32'(m.mem_done));
        check_eq("if_rdata", arb.if_rdata, m.if_rdata);
        check_eq("mem_rdata", arb.mem_rdata, m.mem_rdata);
        check_eq("bus_err", 32'(arb.bus_err), 32'(m.err));
        check_eq("stall_if", 32'(arb.stall_if_req), 32'(arb.if_req & ~m.if_done));
        check_eq("stall_mem", 32'(arb.stall_mem_req), 32'(arb.mem_req & ~m.mem_done));
    endtask

    // Check the current cycle at the falling edge, then advance to 1 unit after the next rise.
    task automatic step();
        @(negedge CLK);
        check_outputs();
        mn = model_next(m);
        prev_if_done  = m.if_done;
        prev_mem_done = m.mem_done;
        @(posedge CLK);
        #1;
        m = mn;
    endtask

    task automatic idle_inputs();
        arb.if_req    = 1'b0;
        arb.if_addr   = 32'h0;
        arb.flush     = 1'b0;
        arb.mem_req   = 1'b0;
        arb.mem_we    = 1'b0;
        arb.mem_addr  = 32'h0;
        arb.mem_wdata = 32'h0;
        arb.mem_sel   = 4'h0;
        arb.bus_rdata = 32'h0;
        arb.bus_ack   = 1'b0;
    endtask

    task automatic drive_random();
        if (arb.if_req) begin
            if (prev_if_done || $urandom_range(0, 39) == 0) arb.if_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            arb.if_req  = 1'b1;
            arb.if_addr = $urandom & 32'h0000_0FFC;
        end
        if (arb.mem_req) begin
            if (prev_mem_done || $urandom_range(0, 39) == 0) arb.mem_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            arb.mem_req   = 1'b1;
            arb.mem_we    = 1'($urandom_range(0, 1));
            arb.mem_addr  = $urandom & 32'h0000_FFFC;
            arb.mem_wdata = $urandom;
            arb.mem_sel   = 4'($urandom_range(1, 15));
        end
        arb.flush     = ($urandom_range(0, 7) == 0);
        arb.bus_ack   = ($urandom_range(0, 2) == 0);
        arb.bus_rdata = $urandom;
    endtask

    initial begin
        idle_inputs();
        m = model_reset();
        #1;

        // Reset held three cycles, then a single fetch acked in its third bus cycle.
        repeat (3) step();
        RST = 1'b1;
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0010;
        step();
        check_eq("t1_bus_req_c1", 32'(arb.bus_req), 32'h1);
        check_eq("t1_bus_sel", 32'(arb.bus_sel), 32'hF);
        check_eq("t1_bus_addr", arb.bus_addr, 32'h0000_0010);
        step();
        step();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h00A0_0093;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t1_if_done", 32'(arb.if_done), 32'h1);
        check_eq("t1_if_rdata", arb.if_rdata, 32'h00A0_0093);
        check_eq("t1_bus_req_c4", 32'(arb.bus_req), 32'h0);
        step();
        arb.if_req = 1'b0;
        step();

        // Simultaneous requests: data first, one idle bubble, then the fetch.
        arb.if_req   = 1'b1;
        arb.if_addr  = 32'h0000_0020;
        arb.mem_req  = 1'b1;
        arb.mem_addr = 32'h0000_0100;
        arb.mem_sel  = 4'hF;
        step();
        check_eq("t2_data_first", arb.bus_addr, 32'h0000_0100);
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h1111_1111;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t2_mem_done", 32'(arb.mem_done), 32'h1);
        check_eq("t2_mem_rdata", arb.mem_rdata, 32'h1111_1111);
        check_eq("t2_bubble", 32'(arb.bus_req), 32'h0);
        step();
        arb.mem_req = 1'b0;
        check_eq("t2_fetch_addr", arb.bus_addr, 32'h0000_0020);
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h2222_2222;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t2_if_done", 32'(arb.if_done), 32'h1);
        check_eq("t2_if_rdata", arb.if_rdata, 32'h2222_2222);
        step();
        arb.if_req = 1'b0;
        step();

        // Store: bus fields held until ack, mem_rdata untouched.
        arb.mem_req   = 1'b1;
        arb.mem_we    = 1'b1;
        arb.mem_addr  = 32'h0000_0200;
        arb.mem_wdata = 32'hDEAD_BEEF;
        arb.mem_sel   = 4'b0011;
        step();
        check_eq("t3_bus_we", 32'(arb.bus_we), 32'h1);
        check_eq("t3_bus_wdata", arb.bus_wdata, 32'hDEAD_BEEF);
        check_eq("t3_bus_sel", 32'(arb.bus_sel), 32'h3);
        step();
        step();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h3333_3333;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t3_mem_done", 32'(arb.mem_done), 32'h1);
        check_eq("t3_mem_rdata_kept", arb.mem_rdata, 32'h1111_1111);
        step();
        arb.mem_req = 1'b0;
        arb.mem_we  = 1'b0;
        step();

        // Flush one cycle after the fetch grant, then a normal fetch to 0x40.
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0030;
        step();
        arb.flush = 1'b1;
        step();
        arb.flush   = 1'b0;
        arb.if_addr = 32'h0000_0040;
        check_eq("t4_drop_holds_bus", 32'(arb.bus_req), 32'h1);
        step();
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h4444_4444;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t4_no_if_done", 32'(arb.if_done), 32'h0);
        check_eq("t4_if_rdata_kept", arb.if_rdata, 32'h2222_2222);
        step();
        check_eq("t4_refetch_addr", arb.bus_addr, 32'h0000_0040);
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h5555_5555;
        step();
        arb.bus_ack = 1'b0;
        check_eq("t4_refetch_done", 32'(arb.if_done), 32'h1);
        check_eq("t4_refetch_rdata", arb.if_rdata, 32'h5555_5555);
        step();
        arb.if_req = 1'b0;
        step();

        // Flush in the same cycle as the ack.
        arb.if_req  = 1'b1;
        arb.if_addr = 32'h0000_0050;
        step();
        arb.flush     = 1'b1;
        arb.bus_ack   = 1'b1;
        arb.bus_rdata = 32'h6666_6666;
        step();
        arb.flush   = 1'b0;
        arb.bus_ack = 1'b0;
        arb.if_req  = 1'b0;
        check_eq("t5_no_if_done", 32'(arb.if_done), 32'h0);
        check_eq("t5_if_rdata_kept", arb.if_rdata, 32'h5555_5555);
        step();

        // Reset in the middle of a load; a late ack must produce nothing.
        arb.mem_req  = 1'b1;
        arb.mem_addr = 32'h0000_0300;
        arb.mem_sel  = 4'hF;
        step();
        check_eq("t6_bus_req_before", 32'(arb.bus_req), 32'h1);
        RST = 1'b0;
        #1;
        check_eq("t6_bus_req_async", 32'(arb.bus_req), 32'h0);
        m = model_reset();
        arb.bus_ack = 1'b1;
        step();
        arb.mem_req = 1'b0;
        RST = 1'b1;
        step();
        step();
        arb.bus_ack = 1'b0;
        check_eq("t6_no_mem_done", 32'(arb.mem_done), 32'h0);
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Unacked load: abandoned after TMO bus_req cycles.
        arb.mem_req  = 1'b1;
        arb.mem_we   = 1'b0;
        arb.mem_addr = 32'h0000_0400;
        repeat (5) step();
        check_eq("t7_bus_err", 32'(arb.bus_err), 32'h1);
        check_eq("t7_mem_done", 32'(arb.mem_done), 32'h1);
        check_eq("t7_mem_rdata", arb.mem_rdata, 32'h0);
        check_eq("t7_bus_req", 32'(arb.bus_req), 32'h0);
        step();
        arb.mem_req = 1'b0;
        step();
`endif

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 800; c++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
